// File: rtl/psum_drain_if.sv
// Handshake bundle for psum_drain: the packed psum input bus and the lane result stream.
// The master side feeds psum beats and consumes results; the slave side is the drain block.
interface psum_drain_if #(
  parameter int unsigned PSUM_W = 52,
  parameter int unsigned ACC_W  = 40
);
  logic              psum_valid;
  logic              psum_ready;
  logic [PSUM_W-1:0] psum_data;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
  logic [1:0]        out_lane;
  logic              out_last;

  modport master (
    output psum_valid, psum_data, out_ready,
    input  psum_ready, out_valid, out_data, out_lane, out_last
  );

  modport slave (
    input  psum_valid, psum_data, out_ready,
    output psum_ready, out_valid, out_data, out_lane, out_last
  );
endinterface

// File: rtl/psum_drain.sv
// psum_drain: accepts packed psum beats, unpacks them into lanes, accumulates each lane over a
// configurable number of beats, then serializes the per-lane totals onto a stream output.
// Optional feature macro: PSUM_DRAIN_SAT_EN (saturating adds; wrap-around when undefined).
module psum_drain #(
  parameter int unsigned PSUM_W    = 52,
  parameter int unsigned LANE_W    = 13,
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned SINGLE_W  = 32,
  parameter int unsigned ACC_W     = 40,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_quad,
  input  logic             cfg_signed,
  input  logic [CNT_W-1:0] cfg_acc_len,
  psum_drain_if.slave      bus
);

  localparam logic [1:0] LastLane = 2'(NUM_LANES - 1);

  typedef enum logic [0:0] {StAcc, StDrain} state_e;

  state_e           r_state;
  logic             r_quad;
  logic             r_signed;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_cnt;
  logic [ACC_W-1:0] r_acc [NUM_LANES];
  logic             r_out_valid;
  logic [ACC_W-1:0] r_out_data;
  logic [1:0]       r_out_lane;
  logic             r_out_last;

  logic             w_first;
  logic             w_quad;
  logic             w_signed;
  logic [CNT_W-1:0] w_len;
  logic [CNT_W:0]   w_len_eff;
  logic             w_beat;
  logic             w_final;
  logic             w_out_hs;
  logic [1:0]       w_next_lane;
  logic [ACC_W-1:0] w_single_s;
  logic [ACC_W-1:0] w_single_u;
  logic [ACC_W-1:0] w_ext     [NUM_LANES];
  logic [ACC_W-1:0] w_acc_nxt [NUM_LANES];

`ifdef PSUM_DRAIN_SAT_EN
  // Clamp on overflow; the clamped value becomes the base for later adds in the group.
  function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b,
                                               input logic             sgn);
    logic [ACC_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sgn) begin
      if ((a[ACC_W-1] == b[ACC_W-1]) && (sum[ACC_W-1] != a[ACC_W-1])) begin
        return a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end
    end else if (sum[ACC_W]) begin
      return '1;
    end
    return sum[ACC_W-1:0];
  endfunction
`else
  function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
    return a + b;
  endfunction
`endif

  // First beat of a group uses the live config; later beats use the latched copy.
  assign w_first     = (r_cnt == '0);
  assign w_quad      = w_first ? cfg_quad    : r_quad;
  assign w_signed    = w_first ? cfg_signed  : r_signed;
  assign w_len       = w_first ? cfg_acc_len : r_len;
  assign w_len_eff   = (w_len == '0) ? (CNT_W+1)'(1) : {1'b0, w_len};
  assign w_beat      = bus.psum_valid && (r_state == StAcc);
  assign w_final     = (({1'b0, r_cnt} + (CNT_W+1)'(1)) == w_len_eff);
  assign w_out_hs    = r_out_valid && bus.out_ready;
  assign w_next_lane = r_out_lane + 2'd1;

  // Ready is a pure decode of the state register, so it is high throughout reset.
  assign bus.psum_ready = (r_state == StAcc);
  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
  assign bus.out_lane   = r_out_lane;
  assign bus.out_last   = r_out_last;

  assign w_single_s = ACC_W'($signed(bus.psum_data[SINGLE_W-1:0]));
  assign w_single_u = ACC_W'(bus.psum_data[SINGLE_W-1:0]);

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    logic [LANE_W-1:0] w_raw;
    logic [ACC_W-1:0]  w_quad_s;
    logic [ACC_W-1:0]  w_quad_u;
    logic [ACC_W-1:0]  w_quad_ext;

    assign w_raw      = bus.psum_data[k*LANE_W +: LANE_W];
    assign w_quad_s   = ACC_W'($signed(w_raw));
    assign w_quad_u   = ACC_W'(w_raw);
    assign w_quad_ext = w_signed ? w_quad_s : w_quad_u;

    if (k == 0) begin : g_lane0
      assign w_ext[k] = w_quad ? w_quad_ext : (w_signed ? w_single_s : w_single_u);
    end else begin : g_laneN
      // Lanes 1..3 carry nothing in single mode.
      assign w_ext[k] = w_quad ? w_quad_ext : '0;
    end

`ifdef PSUM_DRAIN_SAT_EN
    assign w_acc_nxt[k] = w_first ? w_ext[k] : acc_add(r_acc[k], w_ext[k], w_signed);
`else
    assign w_acc_nxt[k] = w_first ? w_ext[k] : acc_add(r_acc[k], w_ext[k]);
`endif
  end

  // Control FSM, accumulators and registered output stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StAcc;
      r_quad      <= 1'b0;
      r_signed    <= 1'b0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_lane  <= 2'd0;
      r_out_last  <= 1'b0;
      for (int k = 0; k < NUM_LANES; k++) r_acc[k] <= '0;
    end else begin
      unique case (r_state)
        StAcc: begin
          if (w_beat) begin
            for (int k = 0; k < NUM_LANES; k++) r_acc[k] <= w_acc_nxt[k];
            if (w_first) begin
              r_quad   <= cfg_quad;
              r_signed <= cfg_signed;
              r_len    <= cfg_acc_len;
            end
            if (w_final) begin
              // Present lane 0 straight from the final sum to save a cycle of latency.
              r_cnt       <= '0;
              r_state     <= StDrain;
              r_out_valid <= 1'b1;
              r_out_lane  <= 2'd0;
              r_out_data  <= w_acc_nxt[0];
              r_out_last  <= !w_quad;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        StDrain: begin
          if (w_out_hs) begin
            if (r_out_last) begin
              r_state     <= StAcc;
              r_out_valid <= 1'b0;
              r_out_data  <= '0;
              r_out_lane  <= 2'd0;
              r_out_last  <= 1'b0;
              for (int k = 0; k < NUM_LANES; k++) r_acc[k] <= '0;
            end else begin
              r_out_lane <= w_next_lane;
              r_out_data <= r_acc[w_next_lane];
              r_out_last <= (w_next_lane == LastLane);
            end
          end
        end
        default: r_state <= StAcc;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_drain.sv
// Directed self-checking bench for psum_drain: a default instance (ACC_W=40) and a narrow
// instance (ACC_W=16) for the overflow case. Expected values are hand-computed constants.
module tb_psum_drain;

  logic       clk;
  logic       rst_n;
  logic       cfg_quad;
  logic       cfg_signed;
  logic [7:0] cfg_acc_len;

  int n_checks = 0;
  int n_errors = 0;

  psum_drain_if #(.PSUM_W(52), .ACC_W(40)) u_if ();
  psum_drain_if #(.PSUM_W(52), .ACC_W(16)) u_if16 ();

  psum_drain u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_quad   (cfg_quad),
    .cfg_signed (cfg_signed),
    .cfg_acc_len(cfg_acc_len),
    .bus        (u_if.slave)
  );

  psum_drain #(.ACC_W(16)) u_dut16 (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_quad   (cfg_quad),
    .cfg_signed (cfg_signed),
    .cfg_acc_len(cfg_acc_len),
    .bus        (u_if16.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [51:0] pack4(input int l3, input int l2, input int l1, input int l0);
    return {13'(l3), 13'(l2), 13'(l1), 13'(l0)};
  endfunction

  // One beat on the main instance; the block must be ready for it.
  task automatic beat(input string tag, input logic [51:0] d);
    chk({tag, "_ready"}, 64'(u_if.psum_ready), 64'd1);
    u_if.psum_valid = 1'b1;
    u_if.psum_data  = d;
    step();
    u_if.psum_valid = 1'b0;
  endtask

  // Drain n lanes with out_ready=1 and check each, then the return to accumulate.
  task automatic drain(input string tag, input int n, input logic [39:0] e0,
                       input logic [39:0] e1, input logic [39:0] e2, input logic [39:0] e3);
    logic [39:0] ev [4];
    ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
    u_if.out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_valid"}, 64'(u_if.out_valid), 64'd1);
      chk({tag, "_data"},  64'(u_if.out_data),  64'(ev[i]));
      chk({tag, "_lane"},  64'(u_if.out_lane),  64'(i));
      chk({tag, "_last"},  64'(u_if.out_last),  64'(i == n - 1));
      chk({tag, "_pready_drain"}, 64'(u_if.psum_ready), 64'd0);
      step();
    end
    chk({tag, "_idle_valid"},  64'(u_if.out_valid),  64'd0);
    chk({tag, "_idle_pready"}, 64'(u_if.psum_ready), 64'd1);
  endtask

  initial begin
    rst_n            = 1'b0;
    cfg_quad         = 1'b1;
    cfg_signed       = 1'b0;
    cfg_acc_len      = 8'd1;
    u_if.psum_valid  = 1'b0;
    u_if.psum_data   = '0;
    u_if.out_ready   = 1'b1;
    u_if16.psum_valid = 1'b0;
    u_if16.psum_data  = '0;
    u_if16.out_ready  = 1'b1;

    // Reset values while rst_n is low.
    #2;
    chk("rst_valid",  64'(u_if.out_valid),  64'd0);
    chk("rst_data",   64'(u_if.out_data),   64'd0);
    chk("rst_lane",   64'(u_if.out_lane),   64'd0);
    chk("rst_last",   64'(u_if.out_last),   64'd0);
    chk("rst_pready", 64'(u_if.psum_ready), 64'd1);
    chk("rst16_valid", 64'(u_if16.out_valid), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Quad unsigned, length 2: 0, 23, 46, 69.
    cfg_quad = 1'b1; cfg_signed = 1'b0; cfg_acc_len = 8'd2;
    beat("q2_b1", pack4(18, 12, 6, 0));
    chk("q2_mid_valid", 64'(u_if.out_valid), 64'd0);
    beat("q2_b2", pack4(51, 34, 17, 0));
    drain("q2", 4, 40'd0, 40'd23, 40'd46, 40'd69);

    // Single signed, length 2: 0xFFFFFF80 + 5 = -123; upper bus bits must be ignored.
    cfg_quad = 1'b0; cfg_signed = 1'b1; cfg_acc_len = 8'd2;
    beat("s2_b1", {20'hABCDE, 32'hFFFF_FF80});
    beat("s2_b2", {20'h12345, 32'h0000_0005});
    drain("s2", 1, 40'hFF_FFFF_FF85, 40'd0, 40'd0, 40'd0);

    // Quad signed, length 1: sign extension of each lane.
    cfg_quad = 1'b1; cfg_signed = 1'b1; cfg_acc_len = 8'd1;
    beat("qs_b1", pack4(4095, -4096, 5, -1));
    drain("qs", 4, 40'hFF_FFFF_FFFF, 40'd5, 40'hFF_FFFF_F000, 40'h00_0000_0FFF);

    // Backpressure: lane 0 held for 3 cycles while psum_valid is held high and stalled.
    cfg_quad = 1'b1; cfg_signed = 1'b0; cfg_acc_len = 8'd1;
    u_if.out_ready = 1'b0;
    beat("bp_b1", pack4(7, 5, 3, 1));
    u_if.psum_valid = 1'b1;
    u_if.psum_data  = pack4(100, 100, 100, 100);
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_valid",  64'(u_if.out_valid),  64'd1);
      chk("bp_hold_data",   64'(u_if.out_data),   64'd1);
      chk("bp_hold_lane",   64'(u_if.out_lane),   64'd0);
      chk("bp_hold_pready", 64'(u_if.psum_ready), 64'd0);
      step();
    end
    u_if.psum_valid = 1'b0;
    drain("bp", 4, 40'd1, 40'd3, 40'd5, 40'd7);

    // Length 0 behaves as 1: every beat is its own group.
    cfg_quad = 1'b1; cfg_signed = 1'b0; cfg_acc_len = 8'd0;
    beat("l0_b1", pack4(4, 3, 2, 1));
    drain("l0a", 4, 40'd1, 40'd2, 40'd3, 40'd4);
    beat("l0_b2", pack4(40, 30, 20, 10));
    drain("l0b", 4, 40'd10, 40'd20, 40'd30, 40'd40);

    // Length 3 with mode and length changed after the first beat: latched config wins.
    cfg_quad = 1'b1; cfg_signed = 1'b0; cfg_acc_len = 8'd3;
    beat("lt_b1", pack4(4, 3, 2, 1));
    cfg_quad = 1'b0; cfg_acc_len = 8'd1;
    beat("lt_b2", pack4(40, 30, 20, 10));
    chk("lt_mid_valid", 64'(u_if.out_valid), 64'd0);
    beat("lt_b3", pack4(400, 300, 200, 100));
    drain("lt", 4, 40'd111, 40'd222, 40'd333, 40'd444);

    // Overflow on the 16-bit instance: 0x9000 + 0x9000.
    cfg_quad = 1'b0; cfg_signed = 1'b0; cfg_acc_len = 8'd2;
    for (int i = 0; i < 2; i++) begin
      chk("ov_ready", 64'(u_if16.psum_ready), 64'd1);
      u_if16.psum_valid = 1'b1;
      u_if16.psum_data  = 52'h0_0000_0000_9000;
      step();
    end
    u_if16.psum_valid = 1'b0;
    chk("ov_valid", 64'(u_if16.out_valid), 64'd1);
`ifdef PSUM_DRAIN_SAT_EN
    chk("ov_data", 64'(u_if16.out_data), 64'h0000_0000_0000_FFFF);
`else
    chk("ov_data", 64'(u_if16.out_data), 64'h0000_0000_0000_2000);
`endif
    chk("ov_lane", 64'(u_if16.out_lane), 64'd0);
    chk("ov_last", 64'(u_if16.out_last), 64'd1);
    step();
    chk("ov_done_valid",  64'(u_if16.out_valid),  64'd0);
    chk("ov_done_pready", 64'(u_if16.psum_ready), 64'd1);

    // Reset during lane 2 of a drain, then a fresh length-1 group.
    cfg_quad = 1'b1; cfg_signed = 1'b0; cfg_acc_len = 8'd2;
    u_if.out_ready = 1'b1;
    beat("rs_b1", pack4(9, 9, 9, 9));
    beat("rs_b2", pack4(1, 1, 1, 1));
    step();
    step();
    chk("rs_pre_lane",  64'(u_if.out_lane),  64'd2);
    chk("rs_pre_valid", 64'(u_if.out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rs_valid",  64'(u_if.out_valid),  64'd0);
    chk("rs_data",   64'(u_if.out_data),   64'd0);
    chk("rs_lane",   64'(u_if.out_lane),   64'd0);
    chk("rs_last",   64'(u_if.out_last),   64'd0);
    chk("rs_pready", 64'(u_if.psum_ready), 64'd1);
    #2;
    rst_n = 1'b1;
    step();
    chk("rs_post_valid", 64'(u_if.out_valid), 64'd0);
    cfg_acc_len = 8'd1;
    beat("rs_b3", pack4(4, 3, 2, 1));
    drain("rs", 4, 40'd1, 40'd2, 40'd3, 40'd4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
